// File: rtl/fetch_controller.sv
// Fetch controller: program load, run/step/halt sequencing and PC update.
// Optional cycle counter output enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_controller #(
  parameter int              SIZE           = 32,
  parameter int              IMEM_ADDR_BITS = 10,
  parameter logic [SIZE-1:0] HALT_WORD      = 32'hFFFFFFFF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load_start,
  input  logic                      i_load_valid,
  input  logic [SIZE-1:0]           i_load_data,
  input  logic                      i_load_done,
  output logic                      o_load_ready,
  input  logic                      i_run,
  input  logic                      i_step,
  input  logic                      i_stall,
  input  logic                      i_jump,
  input  logic [SIZE-1:0]           i_jump_addr,
  input  logic [SIZE-1:0]           i_instruction,
  output logic [SIZE-1:0]           o_pc,
  output logic                      o_pc_en,
  output logic                      o_if_id_flush,
  output logic                      o_imem_we,
  output logic [IMEM_ADDR_BITS-1:0] o_imem_addr,
  output logic [SIZE-1:0]           o_imem_wdata,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [31:0]               o_cycle_count,
`endif
  output logic                      o_halted,
  output logic [2:0]                o_state
);

  localparam int CW = IMEM_ADDR_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [SIZE-1:0]   r_pc;
  logic [SIZE-1:0]   w_pc_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;

  logic w_active;
  logic w_halt;
  logic w_jump;
  logic w_seq;
  logic w_ready;
  logic w_we;
  logic w_enter_load;

  // Counter MSB set means the whole memory has been written.
  assign w_active     = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_halt       = w_active && (i_instruction == HALT_WORD) && !i_stall;
  assign w_jump       = w_active && !w_halt && i_jump;
  assign w_seq        = w_active && !w_halt && !i_jump && !i_stall;
  assign w_ready      = (r_state == S_LOAD) && !r_cnt[CW-1];
  assign w_we         = w_ready && i_load_valid;
  assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_HALT))
                        && i_load_start;

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_cnt_nx   = r_cnt;
    if (w_enter_load) begin
      w_pc_nx  = '0;
      w_cnt_nx = '0;
    end
    if (w_we)
      w_cnt_nx = r_cnt + CW'(1);
    if (w_jump)
      w_pc_nx = {i_jump_addr[SIZE-1:2], 2'b00};
    else if (w_seq)
      w_pc_nx = r_pc + SIZE'(4);
    case (r_state)
      S_IDLE: begin
        if (i_load_start)
          w_state_nx = S_LOAD;
        else if (i_run)
          w_state_nx = S_RUN;
        else if (i_step)
          w_state_nx = S_STEP;
      end
      S_LOAD: begin
        if (i_load_done)
          w_state_nx = S_IDLE;
      end
      S_RUN: begin
        if (w_halt)
          w_state_nx = S_HALT;
      end
      S_STEP: begin
        w_state_nx = w_halt ? S_HALT : S_IDLE;
      end
      S_HALT: begin
        if (i_load_start)
          w_state_nx = S_LOAD;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  always_ff @(posedge clk) begin
    if (rst)
      r_cycle_count <= '0;
    else if (w_enter_load)
      r_cycle_count <= '0;
    else if (w_active)
      r_cycle_count <= r_cycle_count + 32'd1;
  end

  assign o_cycle_count = r_cycle_count;
`endif

  assign o_pc          = r_pc;
  assign o_pc_en       = w_jump || w_seq;
  assign o_if_id_flush = w_jump;
  assign o_load_ready  = w_ready;
  assign o_imem_we     = w_we;
  assign o_imem_addr   = (r_state == S_LOAD) ? r_cnt[IMEM_ADDR_BITS-1:0]
                                              : r_pc[IMEM_ADDR_BITS+1:2];
  assign o_imem_wdata  = w_we ? i_load_data : '0;
  assign o_halted      = (r_state == S_HALT);
  assign o_state       = r_state;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed scenarios plus random stimulus
// checked every cycle against a behavioural model.
module tb_fetch_controller;

  localparam int          AW    = 4;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] HW    = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_load_start;
  logic        i_load_valid;
  logic [31:0] i_load_data;
  logic        i_load_done;
  logic        o_load_ready;
  logic        i_run;
  logic        i_step;
  logic        i_stall;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic [31:0] i_instruction;
  logic [31:0] o_pc;
  logic        o_pc_en;
  logic        o_if_id_flush;
  logic        o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_halted;
  logic [2:0]  o_state;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [31:0] o_cycle_count;
`endif

  fetch_controller #(
    .SIZE(32), .IMEM_ADDR_BITS(AW), .HALT_WORD(HW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_load_start(i_load_start), .i_load_valid(i_load_valid),
    .i_load_data(i_load_data), .i_load_done(i_load_done),
    .o_load_ready(o_load_ready), .i_run(i_run), .i_step(i_step),
    .i_stall(i_stall), .i_jump(i_jump), .i_jump_addr(i_jump_addr),
    .i_instruction(i_instruction), .o_pc(o_pc), .o_pc_en(o_pc_en),
    .o_if_id_flush(o_if_id_flush), .o_imem_we(o_imem_we),
    .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
`ifdef FETCH_CYCLE_COUNT_EN
    .o_cycle_count(o_cycle_count),
`endif
    .o_halted(o_halted), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 load, 2 run, 3 step, 4 halt.
  int           m_mode = 0;
  longint       m_pc   = 0;
  int           m_cnt  = 0;
  longint       m_cc   = 0;
  logic [31:0]  mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
               $time);
    end
  endtask

  function automatic bit m_exec();
    return (m_mode == 2) || (m_mode == 3);
  endfunction

  function automatic bit m_halting();
    return m_exec() && (i_instruction == HW) && !i_stall;
  endfunction

  task automatic check_all();
    bit     ld, full, wr, hl, jp, adv;
    longint ea;
    ld   = (m_mode == 1);
    full = (m_cnt >= DEPTH);
    wr   = ld && !full && i_load_valid;
    hl   = m_halting();
    jp   = m_exec() && !hl && i_jump;
    adv  = m_exec() && !hl && (i_jump || !i_stall);
    ea   = ld ? (m_cnt % DEPTH) : ((m_pc / 4) % DEPTH);
    chk("state", 64'(o_state), 64'(m_mode));
    chk("pc", 64'(o_pc), 64'(m_pc));
    chk("pc_en", 64'(o_pc_en), 64'(adv));
    chk("flush", 64'(o_if_id_flush), 64'(jp));
    chk("load_ready", 64'(o_load_ready), 64'(ld && !full));
    chk("imem_we", 64'(o_imem_we), 64'(wr));
    chk("imem_addr", 64'(o_imem_addr), 64'(ea));
    chk("imem_wdata", 64'(o_imem_wdata), wr ? 64'(i_load_data) : 64'd0);
    chk("halted", 64'(o_halted), 64'(m_mode == 4));
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cycle_count", 64'(o_cycle_count), 64'(m_cc));
`endif
  endtask

  task automatic model_update();
    bit hl, ex;
    hl = m_halting();
    ex = m_exec();
    if (rst) begin
      m_mode = 0; m_pc = 0; m_cnt = 0; m_cc = 0;
      return;
    end
    if (ex) m_cc = (m_cc + 1) % (64'd1 << 32);
    case (m_mode)
      0: begin
        if (i_load_start) begin
          m_mode = 1; m_pc = 0; m_cnt = 0; m_cc = 0;
        end else if (i_run) m_mode = 2;
        else if (i_step) m_mode = 3;
      end
      1: begin
        if (i_load_valid && m_cnt < DEPTH) begin
          mem[m_cnt] = i_load_data;
          m_cnt++;
        end
        if (i_load_done) m_mode = 0;
      end
      2, 3: begin
        if (hl) m_mode = 4;
        else begin
          if (i_jump) m_pc = longint'(i_jump_addr) / 4 * 4;
          else if (!i_stall) m_pc = (m_pc + 4) % (64'd1 << 32);
          if (m_mode == 3) m_mode = 0;
        end
      end
      default: begin
        if (i_load_start) begin
          m_mode = 1; m_pc = 0; m_cnt = 0; m_cc = 0;
        end
      end
    endcase
  endtask

  // Called at the falling edge with inputs set; checks and advances.
  task automatic tick();
    i_instruction = mem[(m_pc / 4) % DEPTH];
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; i_load_start = 0; i_load_valid = 0; i_load_data = 0;
    i_load_done = 0; i_run = 0; i_step = 0; i_stall = 0; i_jump = 0;
    i_jump_addr = 0;
  endtask

  task automatic load_word(input logic [31:0] d, input bit done);
    i_load_valid = 1; i_load_data = d; i_load_done = done;
    tick();
    i_load_valid = 0; i_load_done = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h13;
    idle_inputs();
    i_instruction = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tick();
    rst = 0;
    #1;
    chk("rst_state", 64'(o_state), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_ready", 64'(o_load_ready), 64'd0);
    chk("rst_halted", 64'(o_halted), 64'd0);

    // Three-word program ending in a halt word.
    i_load_start = 1; tick(); i_load_start = 0;
    load_word(32'h20010005, 0);
    load_word(32'h20020007, 0);
    load_word(HW, 0);
    i_load_done = 1; tick(); i_load_done = 0;
    chk("lit_mem0", 64'(mem[0]), 64'h20010005);
    chk("lit_mem2", 64'(mem[2]), 64'(HW));
    chk("lit_load_idle", 64'(o_state), 64'd0);

    i_run = 1; tick(); i_run = 0;
    chk("lit_run_pc0", 64'(o_pc), 64'd0);
    tick();
    chk("lit_run_pc4", 64'(o_pc), 64'd4);
    tick();
    chk("lit_run_pc8", 64'(o_pc), 64'd8);
    tick();
    chk("lit_halt_state", 64'(o_state), 64'd4);
    chk("lit_halt_pc", 64'(o_pc), 64'd8);

    // Full memory load with overflow words; halt only at index 10.
    i_load_start = 1; tick(); i_load_start = 0;
    for (int i = 0; i < DEPTH + 2; i++)
      load_word((i == 10) ? HW : 32'h00100013 + (i << 20), 0);
    #1;
    chk("lit_full_ready", 64'(o_load_ready), 64'd0);
    i_load_done = 1; tick(); i_load_done = 0;

    i_run = 1; tick(); i_run = 0;
    tick();
    chk("lit_pre_stall_pc", 64'(o_pc), 64'd4);
    i_stall = 1;
    #1;
    chk("lit_stall_pc_en", 64'(o_pc_en), 64'd0);
    tick();
    tick();
    chk("lit_stall_pc", 64'(o_pc), 64'd4);
    i_stall = 0; tick();
    chk("lit_post_stall_pc", 64'(o_pc), 64'd8);
    i_jump = 1; i_stall = 1; i_jump_addr = 32'h43;
    #1;
    chk("lit_jump_flush", 64'(o_if_id_flush), 64'd1);
    tick();
    i_stall = 0;
    chk("lit_jump_pc", 64'(o_pc), 64'h40);
    i_jump_addr = 32'hFFFFFFFB; tick(); i_jump = 0;
    chk("lit_jump_hi", 64'(o_pc), 64'hFFFFFFF8);
    tick();
    tick();
    chk("lit_wrap_pc", 64'(o_pc), 64'd0);
    for (int i = 0; i < 30 && m_mode != 4; i++) tick();
    chk("lit_halt2_state", 64'(o_state), 64'd4);
    chk("lit_halt2_pc", 64'(o_pc), 64'h28);

    // Single step from idle.
    i_load_start = 1; tick(); i_load_start = 0;
    i_load_done = 1; tick(); i_load_done = 0;
    i_step = 1; tick(); i_step = 0;
    tick();
    chk("lit_step_pc", 64'(o_pc), 64'd4);
    chk("lit_step_state", 64'(o_state), 64'd0);

    // Reset in the middle of a load.
    i_load_start = 1; tick(); i_load_start = 0;
    for (int i = 0; i < 5; i++) load_word(32'hA0 + i, 0);
    rst = 1; tick(); rst = 0;
    #1;
    chk("lit_rst_load_state", 64'(o_state), 64'd0);
    chk("lit_rst_load_ready", 64'(o_load_ready), 64'd0);
    i_load_start = 1; tick(); i_load_start = 0;
    i_load_valid = 1; i_load_data = 32'h55;
    #1;
    chk("lit_rst_cnt", 64'(o_imem_addr), 64'd0);
    tick();
    i_load_valid = 0;

    // Random stimulus.
    for (int n = 0; n < 4000; n++) begin
      rst          = ($urandom % 200) == 0;
      i_load_start = ($urandom % 20) == 0;
      i_load_valid = ($urandom % 2) == 0;
      i_load_data  = (($urandom % 6) == 0) ? HW : $urandom;
      i_load_done  = ($urandom % 12) == 0;
      i_run        = ($urandom % 8) == 0;
      i_step       = ($urandom % 8) == 0;
      i_stall      = ($urandom % 4) == 0;
      i_jump       = ($urandom % 8) == 0;
      i_jump_addr  = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
